// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pkg: shared widths and fetch state encoding   | Rev 1.0              |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned DROP_W = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_skid_buffer: one-entry holding slot for a stalled fetch response | 1.0 |
// +----------------------------------------------------------------------------+
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [ILEN-1:0] data_i,
    input  logic [ILEN-1:0] pc_i,
    output logic [ILEN-1:0] data_o,
    output logic [ILEN-1:0] pc_o,
    output logic            valid_o
);

    logic [ILEN-1:0] data_q;
    logic [ILEN-1:0] pc_q;
    logic            valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_controller: instruction fetch with redirect, stale drop and skid | 1.0 |
// +----------------------------------------------------------------------------+
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [ILEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] InstrD,
    output logic [ILEN-1:0] PCD,
    output logic [ILEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e      state_q, state_d;
    logic [ILEN-1:0]   pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [ILEN-1:0]   pcd_q, pcd_d;
    logic [ILEN-1:0]   pcp4_q, pcp4_d;
    logic              valid_q, valid_d;

    logic              skid_load, skid_unload, skid_clear, skid_valid;
    logic [ILEN-1:0]   skid_data, skid_pc;
    logic              accept, stale, live_rsp, cur_out;

    // drop_q counts responses already owed by memory for abandoned requests;
    // issue is held off at saturation so the count can never wrap.
    assign imem_req  = (state_q == REQ) && (drop_q != '1);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign stale     = imem_rvalid && (drop_q != '0) && ((state_q == REQ) || (state_q == WAIT));
    assign live_rsp  = imem_rvalid && (drop_q == '0) && (state_q == WAIT);
    assign cur_out   = ((state_q == REQ) && accept) || ((state_q == WAIT) && !live_rsp);
    assign drop_d    = drop_q - DROP_W'(stale) + DROP_W'(PCSrcE && cur_out);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q && StallD;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (live_rsp) begin
                    if (StallD && valid_q) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        pcp4_d  = pc_q + ILEN'(4);
                        valid_d = 1'b1;
                        pc_d    = pc_q + ILEN'(4);
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                if (!StallD) begin
                    instr_d     = skid_data;
                    pcd_d       = skid_pc;
                    pcp4_d      = skid_pc + ILEN'(4);
                    valid_d     = skid_valid;
                    skid_unload = 1'b1;
                    pc_d        = pc_q + ILEN'(4);
                    state_d     = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
        // A redirect overrides everything, including a stalled Decode.
        if (PCSrcE) begin
            pc_d        = PCTargetE & ~ILEN'(3);
            valid_d     = 1'b0;
            skid_clear  = 1'b1;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            state_d     = REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            instr_q <= '0;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (imem_rdata),
        .pc_i     (pc_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc),
        .valid_o  (skid_valid)
    );

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_controller: table, directed and random checks of fetch_controller |
// +----------------------------------------------------------------------------+
module tb_fetch_controller;

    logic        clk, rst, PCSrcE, StallD, imem_ready, imem_rvalid;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req, ValidD, imem_req2, ValidD2;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
    logic [31:0] imem_addr2, InstrD2, PCD2, PCPlus4D2;

    fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    // Same control timing as dut, only the address space is offset by the reset PC.
    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pcd;
    } vec_t;

    mreq_t       mq[$];
    vec_t        vt[14];
    int          total = 0, bad = 0, cyc = 0, consumed = 0;
    int          lat_min = 1, lat_max = 1;
    logic        inj_rv = 1'b0;
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    logic        p_valid, p_stall, p_redir;
    logic [31:0] p_instr, p_pcd, p_pcp4, p_tgt;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: memory responder, pre-edge stream checks, edge, post-edge rule checks.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        mreq_t       e;
        if (inj_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = insn_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        acc     = imem_req && imem_ready && !rst;
        a       = imem_addr;
        p_valid = ValidD;  p_stall = StallD;  p_redir = PCSrcE; p_tgt = PCTargetE;
        p_instr = InstrD;  p_pcd   = PCD;     p_pcp4  = PCPlus4D;
        if (!rst) begin
            if (pend) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_held", imem_addr, pend_addr);
            end
            if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (ValidD && !StallD) begin
                check("stream_pcd", PCD, exp_pc);
                check("stream_instr", InstrD, insn_of(exp_pc));
                check("stream_pcp4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
        pend      = imem_req && !imem_ready && !PCSrcE && !rst;
        pend_addr = imem_addr;
        @(posedge clk);
        #1;
        if (imem_rvalid && !inj_rv && mq.size() != 0) void'(mq.pop_front());
        if (acc) begin
            e.addr = a;
            e.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mq.push_back(e);
        end
        cyc++;
        if (!rst) begin
            if (p_redir) begin
                check("flush_valid", {31'b0, ValidD}, 32'd0);
                exp_pc = p_tgt & ~32'd3;
            end else if (p_valid && p_stall) begin
                check("stall_valid", {31'b0, ValidD}, 32'd1);
                check("stall_pcd", PCD, p_pcd);
                check("stall_instr", InstrD, p_instr);
                check("stall_pcp4", PCPlus4D, p_pcp4);
            end
        end
    endtask

    task automatic chk_reset_vals();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, ValidD}, 32'd0);
        check("rst_instr", InstrD, 32'h0);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pcp4", PCPlus4D, 32'h0);
        check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
    endtask

    task automatic release_reset();
        rst    = 1'b0;
        mq.delete();
        exp_pc = 32'h0;
        pend   = 1'b0;
        StallD = 1'b0;
        PCSrcE = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; imem_ready = 1'b0; inj_rv = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) tick();
        release_reset();
        imem_ready = 1'b1;
    endtask

    task automatic wait_accept(input logic [31:0] addr, input string nm);
        logic found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (imem_req && imem_ready && imem_addr == addr) found = 1'b1;
            tick();
        end
        check(nm, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_valid(input logic [31:0] pcd, input string nm);
        logic found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (ValidD) found = 1'b1;
            else tick();
        end
        check({nm, "_seen"}, {31'b0, found}, 32'd1);
        check({nm, "_pcd"}, PCD, pcd);
        check({nm, "_instr"}, InstrD, insn_of(pcd));
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend = 1'b0; exp_pc = 32'h0;

        // Free run with 1-cycle memory, then a 5-cycle Decode stall over the 0x8 response.
        vt[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vt[6]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h4};
        vt[7]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h4};
        vt[8]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h4};
        vt[9]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h4};
        vt[10] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h4};
        vt[11] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h8};
        vt[12] = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h0};
        vt[13] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            StallD = vt[i].stall;
            check("tbl_req", {31'b0, imem_req}, {31'b0, vt[i].exp_req});
            check("tbl_addr", imem_addr, vt[i].exp_addr);
            check("tbl_valid", {31'b0, ValidD}, {31'b0, vt[i].exp_valid});
            check("tbl_addr_wrap", imem_addr2, vt[i].exp_addr + 32'hFFFF_FFFC);
            if (vt[i].exp_valid) begin
                check("tbl_pcd", PCD, vt[i].exp_pcd);
                check("tbl_pcp4", PCPlus4D, vt[i].exp_pcd + 32'd4);
                check("tbl_instr", InstrD, insn_of(vt[i].exp_pcd));
                check("tbl_pcd_wrap", PCD2, vt[i].exp_pcd + 32'hFFFF_FFFC);
                check("tbl_pcp4_wrap", PCPlus4D2, vt[i].exp_pcd);
            end
            tick();
        end

        // Redirect during WAIT for 0x8 with slow memory: stale response must be dropped.
        lat_min = 3; lat_max = 3;
        do_reset();
        wait_accept(32'h8, "wait_acc8_a");
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        tick();
        PCSrcE = 1'b0;
        check("redir_valid", {31'b0, ValidD}, 32'd0);
        check("redir_req", {31'b0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        wait_valid(32'h100, "redir_deliver");

        // Redirect in the same cycle as the response.
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_accept(32'h8, "wait_acc8_b");
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        tick();
        PCSrcE = 1'b0;
        check("same_valid", {31'b0, ValidD}, 32'd0);
        check("same_req", {31'b0, imem_req}, 32'd1);
        check("same_addr", imem_addr, 32'h40);
        wait_valid(32'h40, "same_deliver");

        // Asynchronous reset mid-transaction, then a stale rvalid during BOOT.
        lat_min = 4; lat_max = 4;
        do_reset();
        wait_valid(32'h0, "pre_rst");
        StallD = 1'b1;
        tick();
        check("pre_rst_wait", {31'b0, imem_req}, 32'd0);
        imem_ready = 1'b0;
        #3 rst = 1'b1;
        #1 chk_reset_vals();
        repeat (2) tick();
        release_reset();
        inj_rv = 1'b1;
        check("boot_req", {31'b0, imem_req}, 32'd0);
        tick();
        inj_rv = 1'b0;
        check("boot_valid", {31'b0, ValidD}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            check("notready_req", {31'b0, imem_req}, 32'd1);
            check("notready_addr", imem_addr, 32'h0);
            tick();
        end
        imem_ready = 1'b1;
        wait_valid(32'h0, "post_rst");

        // Random traffic against the delivered-stream model.
        lat_min = 1; lat_max = 3;
        do_reset();
        consumed = 0;
        for (int n = 0; n < 4000; n++) begin
            StallD     = ($urandom_range(99) < 30);
            imem_ready = ($urandom_range(99) < 75);
            PCSrcE     = ($urandom_range(99) < 5);
            PCTargetE  = $urandom;
            tick();
        end
        PCSrcE = 1'b0;
        check("progress", {31'b0, consumed > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset SHALL be RESET_PC.
REQ-002 clk  in  1: the single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1: reset, asynchronous and active-high.
REQ-004 PCSrcE  in  1: redirect request from Execute.
REQ-005 PCTargetE  in  32: redirect target address.
REQ-006 StallD  in  1: Decode stall; when high, Decode SHALL NOT consume the current D outputs.
REQ-007 imem_req  out  1: instruction memory request valid.
REQ-008 imem_addr  out  32: request address, word-aligned.
REQ-009 imem_ready  in  1: request accepted in the current cycle when both imem_req and imem_ready are high.
REQ-010 imem_rvalid  in  1: response valid; it arrives one or more cycles after acceptance.
REQ-011 imem_rdata  in  32: response instruction word.
REQ-012 InstrD, PCD, PCPlus4D  out  32 each: Fetch-to-Decode pipeline registers.
REQ-013 ValidD  out  1: the D outputs hold a live instruction.

Function
REQ-014 The state machine SHALL have four states: BOOT, REQ, WAIT and HOLD.
REQ-015 BOOT SHALL be entered on reset and SHALL last one cycle with imem_req=0, then go to REQ.
REQ-016 REQ SHALL drive imem_req=1 and imem_addr=PC, holding both stable until acceptance, then go to WAIT.
REQ-017 At most one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and HOLD.
REQ-018 On imem_rvalid in WAIT with no drop pending and (StallD=0 or ValidD=0), the D registers SHALL load InstrD=imem_rdata, PCD=PC, PCPlus4D=PC+4, ValidD=1 on that edge, and the block SHALL then go to REQ with PC<=PC+4.
REQ-019 On imem_rvalid in WAIT with StallD=1 and ValidD=1, the response and its PC SHALL be captured in a one-entry skid buffer and the block SHALL go to HOLD.
REQ-020 In HOLD, when StallD=0 the skid buffer SHALL move into the D registers, ValidD SHALL stay 1, PC SHALL advance by 4, and the block SHALL go to REQ.
REQ-021 While StallD=1 and ValidD=1, InstrD, PCD, PCPlus4D and ValidD SHALL hold their values.
REQ-022 When StallD=0 and no new instruction loads, ValidD SHALL clear on the next edge.
REQ-023 PCSrcE=1 in any state SHALL, on that edge:
  - set PC<=PCTargetE with bits [1:0] forced to 0;
  - clear ValidD (flush);
  - invalidate the skid buffer;
  - go to REQ.
REQ-024 Redirect SHALL take priority over StallD.
REQ-025 A redirect while a request is accepted but unanswered SHALL set a drop flag; the next imem_rvalid SHALL be discarded and the flag cleared.
REQ-026 A redirect in the same cycle as imem_rvalid SHALL discard that response, with no drop flag set.
REQ-027 A redirect in the same cycle as acceptance in REQ SHALL set the drop flag.
REQ-028 In REQ with the drop flag set, the new request SHALL be issued; the stale response SHALL still be discarded first.
REQ-029 All PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-030 Best-case throughput SHALL be one instruction per two cycles with 1-cycle memory latency.

Reset
REQ-031 While rst=1, regardless of clk:
  - PC=RESET_PC and state=BOOT;
  - imem_req=0 and imem_addr=RESET_PC;
  - InstrD=0, PCD=0, PCPlus4D=0, ValidD=0;
  - drop flag and skid buffer cleared.
REQ-032 A reset asserted mid-transaction SHALL abandon the transaction; the first rvalid after reset release SHALL be accepted only for a request issued after reset.

Structure
REQ-033 The state encoding and the instruction width constant (32) SHALL reside in the shared riscv_pkg package.
REQ-034 The skid buffer SHALL be a sub-module named fetch_skid_buffer (data, pc, valid; load/unload/clear).

Verification
REQ-035 Reset then free run, 1-cycle memory, StallD=0 -> imem_addr 0x0,0x4,0x8; ValidD pulses with PCD 0x0,0x4,0x8; PCPlus4D=PCD+4.
REQ-036 StallD=1 for 5 cycles while instruction at 0x4 is in D and 0x8 returns -> D holds 0x4, 0x8 sits in the skid buffer; StallD=0 -> PCD=0x8 next edge; no fetch is lost or duplicated.
REQ-037 PCSrcE=1, PCTargetE=0x103 during WAIT for 0x8 -> ValidD=0 next edge; the stale rvalid is dropped; next imem_addr=0x100; PCD=0x100 is delivered.
REQ-038 PCSrcE and imem_rvalid in the same cycle, target 0x40 -> the response is never presented; the next request is to 0x40.
REQ-039 RESET_PC=32'hFFFF_FFFC -> the first PCD=0xFFFFFFFC with PCPlus4D=0x0; the next imem_addr=0x0.
REQ-040 rst pulsed while in WAIT with imem_ready held low for 3 cycles -> all outputs return to reset values immediately; imem_req stays 0 for one BOOT cycle.
